// File: rtl/npower_pkg.sv
// Shared constants and types for the nPower front end.
package npower_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry hold buffer. The hold buffer keeps a
// fetched word while decode is stalled.
module if_id_reg
    import npower_pkg::*;
#(
    parameter int PC_W    = npower_pkg::PC_W,
    parameter int INSTR_W = npower_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               capture,
    input  logic               release_hold,
    input  logic               stall,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               free,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr
);

    logic               valid_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [PC_W-1:0]    hold_pc_reg;
    logic [INSTR_W-1:0] hold_instr_reg;

    // A stall against a bubble is ignored, so an empty register always accepts.
    assign free     = !valid_reg || !stall;
    assign id_valid = valid_reg;
    assign id_pc    = pc_reg;
    assign id_instr = instr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= 1'b0;
            pc_reg         <= '0;
            instr_reg      <= '0;
            hold_pc_reg    <= '0;
            hold_instr_reg <= '0;
        end else if (flush) begin
            valid_reg      <= 1'b0;
            instr_reg      <= '0;
            hold_pc_reg    <= '0;
            hold_instr_reg <= '0;
        end else begin
            if (capture) begin
                hold_pc_reg    <= pc_in;
                hold_instr_reg <= instr_in;
            end
            if (load) begin
                valid_reg <= 1'b1;
                pc_reg    <= pc_in;
                instr_reg <= instr_in;
            end else if (release_hold) begin
                valid_reg <= 1'b1;
                pc_reg    <= hold_pc_reg;
                instr_reg <= hold_instr_reg;
            end else if (free) begin
                valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding memory handshake and IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module fetch_stage
    import npower_pkg::*;
#(
    parameter int              PC_W     = npower_pkg::PC_W,
    parameter int              INSTR_W  = npower_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               id_stall,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               fetch_misalign
);

    localparam logic [PC_W-1:0] STEP     = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(3);

    fetch_state_t    state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] redirect_target;
    logic            redirect_bad;
    logic            redirect_act;
    logic            id_free;
    logic            resp_ok;
    logic            pending_after;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_reg;
    assign redirect_target = redirect_pc;
    assign redirect_bad    = |redirect_pc[1:0];
    assign fetch_misalign  = misalign_reg;
`else
    assign redirect_target = redirect_pc & ~LOW_MASK;
    assign redirect_bad    = 1'b0;
    assign fetch_misalign  = 1'b0;
`endif

    assign redirect_act = redirect_valid && (state_reg != S_HALT);
    // A response in a redirect cycle is stale and never used.
    assign resp_ok      = (state_reg == S_WAIT) && imem_rvalid && !redirect_valid;
    assign pending_after = ((state_reg == S_WAIT) || (state_reg == S_DROP)) && !imem_rvalid;

    assign imem_req  = !rst && !redirect_valid &&
                       ((state_reg == S_REQ) ||
                        ((state_reg == S_WAIT) && imem_rvalid && id_free));
    assign imem_addr = (state_reg == S_WAIT) ? pc_reg + STEP : pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_REQ;
            pc_reg    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_reg <= 1'b0;
`endif
        end else if (redirect_act) begin
            pc_reg <= redirect_target;
            if (redirect_bad) begin
                state_reg <= S_HALT;
`ifdef FETCH_ALIGN_CHECK_EN
                misalign_reg <= 1'b1;
`endif
            end else if (pending_after) begin
                state_reg <= S_DROP;
            end else begin
                state_reg <= S_REQ;
            end
        end else begin
            case (state_reg)
                S_REQ: state_reg <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (id_free) begin
                            pc_reg <= pc_reg + STEP;
                        end else begin
                            state_reg <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_free) begin
                        pc_reg    <= pc_reg + STEP;
                        state_reg <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_reg <= S_REQ;
                    end
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirect_act),
        .load         (resp_ok && id_free),
        .capture      (resp_ok && !id_free),
        .release_hold ((state_reg == S_HOLD) && id_free && !redirect_valid),
        .stall        (id_stall),
        .pc_in        (pc_reg),
        .instr_in     (imem_rdata),
        .free         (id_free),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_instr     (id_instr)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle instruction memory that can be
// held off to leave a request pending.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        fetch_misalign;

    logic        mem_delay;
    logic        pend_reg;
    logic [63:0] paddr_reg;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .fetch_misalign (fetch_misalign)
    );

    function automatic logic [31:0] word_at(input logic [63:0] a);
        case (a)
            64'h0:   word_at = 32'h0000_001F;
            64'h4:   word_at = 32'h0000_000E;
            64'h8:   word_at = 32'h0000_001C;
            default: word_at = a[31:0] ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory answers one cycle after the request unless mem_delay holds it off.
    assign imem_rvalid = pend_reg && !mem_delay;
    assign imem_rdata  = word_at(paddr_reg);

    always @(posedge clk) begin
        if (rst) begin
            pend_reg  <= 1'b0;
            paddr_reg <= '0;
        end else if (imem_req) begin
            pend_reg  <= 1'b1;
            paddr_reg <= imem_addr;
        end else if (imem_rvalid) begin
            pend_reg <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    // Inputs set on the falling edge apply to the next rising edge.
    task automatic drive(input logic rdir, input logic [63:0] rpc, input logic stall, input logic dly);
        @(negedge clk);
        redirect_valid = rdir;
        redirect_pc    = rpc;
        id_stall       = stall;
        mem_delay      = dly;
        #1;
    endtask

    task automatic check_id(input string tag, input logic [63:0] pc, input logic [31:0] instr);
        check({tag, ".valid"}, id_valid, 1);
        check({tag, ".pc"}, id_pc, pc);
        check({tag, ".instr"}, id_instr, instr);
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_stall = 1'b0;
        mem_delay = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst.id_valid", id_valid, 0);
        check("rst.id_pc", id_pc, 0);
        check("rst.id_instr", id_instr, 0);
        check("rst.imem_req", imem_req, 0);
        check("rst.misalign", fetch_misalign, 0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first.req", imem_req, 1);
        check("first.addr", imem_addr, 64'h0);

        drive(0, 0, 0, 0);
        check("c1.id_valid", id_valid, 0);
        check("c1.req", imem_req, 1);
        check("c1.addr", imem_addr, 64'h4);
        drive(0, 0, 0, 0);
        check_id("i0", 64'h0, 32'h0000_001F);
        drive(0, 0, 0, 0);
        check_id("i1", 64'h4, 32'h0000_000E);

        // Stall for three cycles while the word at 0xC arrives.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            check_id("stall", 64'h8, 32'h0000_001C);
            check("stall.req", imem_req, 0);
        end
        drive(0, 0, 0, 0);
        check_id("unstall", 64'h8, 32'h0000_001C);
        check("hold.req", imem_req, 0);
        drive(0, 0, 0, 0);
        check_id("held", 64'hC, 32'hA5A5_000C);
        check("held.req", imem_req, 1);
        check("held.addr", imem_addr, 64'h10);
        drive(0, 0, 0, 0);
        check("bubble.valid", id_valid, 0);
        check("bubble.addr", imem_addr, 64'h14);

        // Redirect with the request still pending: stale reply must be dropped.
        drive(1, 64'h100, 0, 1);
        check_id("i10", 64'h10, 32'hA5A5_0010);
        check("rdp.req", imem_req, 0);
        drive(0, 0, 0, 0);
        check("drop.valid", id_valid, 0);
        check("drop.req", imem_req, 0);
        drive(0, 0, 0, 0);
        check("drop.after.valid", id_valid, 0);
        check("drop.after.req", imem_req, 1);
        check("drop.after.addr", imem_addr, 64'h100);
        drive(0, 0, 0, 0);
        check("r100.valid", id_valid, 0);
        check("r100.addr", imem_addr, 64'h104);

        // Redirect coinciding with a response: no drop state.
        drive(1, 64'h100, 0, 0);
        check_id("i100", 64'h100, 32'hA5A5_0100);
        check("rdv.req", imem_req, 0);
        drive(0, 0, 0, 0);
        check("rdv.valid", id_valid, 0);
        check("rdv.req2", imem_req, 1);
        check("rdv.addr", imem_addr, 64'h100);

        // PC wrap-around.
        drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        check("wrap.rd.req", imem_req, 0);
        drive(0, 0, 0, 0);
        check("wrap.req", imem_req, 1);
        check("wrap.addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(0, 0, 0, 0);
        check("wrap.addr1", imem_addr, 64'h0);

        // Misaligned redirect.
        drive(1, 64'h102, 0, 0);
        check_id("iwrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'h5A5A_FFFC);
`ifdef FETCH_ALIGN_CHECK_EN
        drive(0, 0, 0, 0);
        check("mis.flag", fetch_misalign, 1);
        check("mis.valid", id_valid, 0);
        check("mis.req", imem_req, 0);
        drive(1, 64'h200, 0, 0);
        check("halt.req0", imem_req, 0);
        drive(0, 0, 0, 0);
        check("halt.req1", imem_req, 0);
        check("halt.flag", fetch_misalign, 1);
`else
        drive(0, 0, 0, 0);
        check("mis.flag", fetch_misalign, 0);
        check("mis.valid", id_valid, 0);
        check("mis.req", imem_req, 1);
        check("mis.addr", imem_addr, 64'h100);
        drive(1, 64'h200, 0, 0);
        check("mis.rd.req", imem_req, 0);
        drive(0, 0, 0, 0);
        check("mis.next.addr", imem_addr, 64'h200);
`endif

        // Reset in the middle of operation.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst.req", imem_req, 0);
        @(negedge clk);
        #1;
        check("mrst.valid", id_valid, 0);
        check("mrst.misalign", fetch_misalign, 0);
        check("mrst.id_pc", id_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst.first.req", imem_req, 1);
        check("mrst.first.addr", imem_addr, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
